user_obi_mgr_arb: RTL and testbench
===================================

USER_OBI_MGR_ARB -- requirements
Module: user_obi_mgr_arb

Interface
REQ-001 SHALL have parameter NumMgr, default 2, number of user OBI managers sharing the single user manager port (1..8).
REQ-002 SHALL have parameter NumMaxTrans, default 4, maximum outstanding granted-but-unanswered transactions (1..16).
REQ-003 SHALL have parameter RoundRobin, default 1'b1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i is the single clock, and rst_i is the synchronous, active-high reset.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous reset, active high.
REQ-007 mgr_req_i  input  NumMgr x mgr_obi_req_t  requests from user managers (req, addr, we, be, wdata, aid).
REQ-008 mgr_rsp_o  output  NumMgr x mgr_obi_rsp_t  per-manager gnt, rvalid, rdata, err, rid.
REQ-009 out_req_o  output  mgr_obi_req_t  arbitrated request toward the croc subordinate side.
REQ-010 out_rsp_i  input  mgr_obi_rsp_t  gnt/response from the croc subordinate side.
REQ-011 outstanding_o  output  clog2(NumMaxTrans+1)  current outstanding transaction count.
REQ-012 unexp_rsp_o  output  1  sticky flag, set by a response arriving with no outstanding transaction.

Function
REQ-013 Arbitration SHALL be combinational over the mgr_req_i req bits; the winner's a-channel is forwarded on out_req_o and out_req_o.req = OR of requests, gated by REQ-016.
REQ-014 Once out_req_o.req is high without out_rsp_i.gnt, the selected index SHALL be locked and held until the handshake, regardless of new higher-priority requests (OBI stability).
REQ-015 out_rsp_i.gnt SHALL be routed only to the selected manager's gnt; all other gnt outputs are 0.
REQ-016 When the ID FIFO holds NumMaxTrans entries, out_req_o.req and all gnt outputs SHALL be 0; a same-cycle pop does not unblock (no rvalid-to-req path).
REQ-017 On each handshake (out_req_o.req & out_rsp_i.gnt) the winner index SHALL be pushed into the ID FIFO.
REQ-018 Round-robin: after a handshake by index k the priority pointer SHALL move to (k+1) mod NumMgr; the pointer is unchanged in cycles without a handshake.
REQ-019 On out_rsp_i.rvalid with a non-empty FIFO, the head SHALL be popped and rvalid asserted only on mgr_rsp_o[head]; rdata, err and rid are broadcast to all managers.
REQ-020 On rvalid with an empty FIFO, the response SHALL be dropped (no rvalid out) and unexp_rsp_o set; it stays set until reset.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-022 outstanding_o SHALL equal the FIFO occupancy and update one cycle after the push or pop event.
REQ-023 Fixed-priority mode SHALL never update the pointer; index 0 has highest priority.

Reset
REQ-024 On rst_i high at a clock edge: FIFO emptied, lock cleared, pointer set to 0, unexp_rsp_o = 0, outstanding_o = 0.
REQ-025 During reset and the first cycle after it: out_req_o.req = 0, all gnt = 0, all rvalid = 0.
REQ-026 Reset mid-transaction SHALL discard all pending IDs; a later stray rvalid is treated per REQ-020.

Structure
REQ-027 user_pkg SHALL hold the NumUserMgr constant and the arbitration-mode constants; the OBI types come from the existing user_pkg/croc_pkg typedefs.
REQ-028 The ID FIFO SHALL be a sub-module user_obi_id_fifo (parametrised width/depth, synchronous active-high reset, full/empty/count outputs).

Verification
REQ-029 NumMgr=2: mgr0 and mgr1 request every cycle, gnt always 1, rvalid one cycle later -> grants alternate 0,1,0,1; each rvalid is routed to the matching manager.
REQ-030 mgr1 requests and gnt is held 0 for 3 cycles, then mgr0 also requests -> the selection stays on mgr1 and its addr is stable until gnt.
REQ-031 NumMaxTrans=4: 4 handshakes with no rvalid -> outstanding_o=4 and req/gnt blocked; one rvalid -> outstanding_o=3 next cycle, then requests resume.
REQ-032 rvalid with an empty FIFO after reset -> no mgr rvalid, unexp_rsp_o=1 and sticky until rst_i.
REQ-033 RoundRobin=0: both managers request continuously -> mgr0 is granted every cycle and mgr1 is starved.
REQ-034 rst_i asserted with 2 outstanding -> outstanding_o=0 after the edge and FIFO empty; the next rvalid sets unexp_rsp_o.

Source files
------------

// File: rtl/user_obi_mgr_arb_pkg.sv
// Shared constants and OBI manager-side request/response types for the user
// manager arbiter and its ID FIFO.
package user_obi_mgr_arb_pkg;

    localparam int unsigned NumUserMgr    = 2;
    localparam bit          ArbRoundRobin = 1'b1;
    localparam bit          ArbFixedPrio  = 1'b0;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 1;

    typedef struct packed {
        logic                   req;
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic                 gnt;
        logic                 rvalid;
        logic [DataWidth-1:0] rdata;
        logic                 err;
        logic [IdWidth-1:0]   rid;
    } mgr_obi_rsp_t;

    // Index width that stays legal for a single manager.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_obi_mgr_arb_if.sv
// Bundle of the arbiter's manager-facing and subordinate-facing OBI signals.
// slave = arbiter view, master = the surrounding system (managers + croc side).
interface user_obi_mgr_arb_if
    import user_obi_mgr_arb_pkg::*;
#(
    parameter int unsigned NumMgr      = NumUserMgr,
    parameter int unsigned NumMaxTrans = 4
);
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    mgr_obi_req_t [NumMgr-1:0] mgr_req_i;
    mgr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o;
    mgr_obi_req_t              out_req_o;
    mgr_obi_rsp_t              out_rsp_i;
    logic [CntW-1:0]           outstanding_o;
    logic                      unexp_rsp_o;

    modport slave (
        input  mgr_req_i, out_rsp_i,
        output mgr_rsp_o, out_req_o, outstanding_o, unexp_rsp_o
    );

    modport master (
        output mgr_req_i, out_rsp_i,
        input  mgr_rsp_o, out_req_o, outstanding_o, unexp_rsp_o
    );

endinterface

// File: rtl/user_obi_id_fifo.sv
// Small circular FIFO remembering which manager owns each outstanding
// transaction; push on full and pop on empty are ignored.
module user_obi_id_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [Width-1:0]               data_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  cnt;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt == CntW'(Depth));
    assign empty_o = (cnt == '0);
    assign count_o = cnt;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/user_obi_mgr_arb.sv
// Arbitrates several user OBI managers onto one manager port; an ID FIFO
// routes each in-order response back to the manager that issued it.
module user_obi_mgr_arb
    import user_obi_mgr_arb_pkg::*;
#(
    parameter int unsigned NumMgr      = NumUserMgr,
    parameter int unsigned NumMaxTrans = 4,
    parameter bit          RoundRobin  = ArbRoundRobin
) (
    input  logic               clk_i,
    input  logic               rst_i,
    user_obi_mgr_arb_if.slave  bus
);
    localparam int unsigned IdxW = idx_width(NumMgr);
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    logic [NumMgr-1:0] req_vec;
    logic [IdxW-1:0]   rr_ptr_q, lock_idx_q, arb_idx, head_idx;
    logic              lock_q, en_q, unexp_q;
    logic              active, out_req, hs, pop;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_cnt;

    // First requester at or after start, wrapping around.
    function automatic logic [IdxW-1:0] pick(input logic [NumMgr-1:0] rv,
                                             input logic [IdxW-1:0]   start);
        int unsigned j;
        logic        found;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            j = 32'(start) + k;
            if (j >= NumMgr) j = j - NumMgr;
            if (!found && rv[IdxW'(j)]) begin
                pick  = IdxW'(j);
                found = 1'b1;
            end
        end
    endfunction

    // A stalled request keeps its manager until the handshake completes.
    assign arb_idx = lock_q ? lock_idx_q
                            : pick(req_vec, RoundRobin ? rr_ptr_q : '0);

    // en_q holds requests off for the cycle following reset.
    assign active  = en_q & ~rst_i;
    // Full blocks on occupancy alone; a same-cycle pop never frees a slot.
    assign out_req = active & (|req_vec) & ~fifo_full;
    assign hs      = out_req & bus.out_rsp_i.gnt;
    assign pop     = ~rst_i & bus.out_rsp_i.rvalid & ~fifo_empty;

    always_comb begin
        bus.out_req_o     = bus.mgr_req_i[arb_idx];
        bus.out_req_o.req = out_req;
    end

    for (genvar i = 0; i < NumMgr; i++) begin : g_mgr
        assign req_vec[i]             = bus.mgr_req_i[i].req;
        assign bus.mgr_rsp_o[i].gnt    = hs  & (arb_idx  == IdxW'(i));
        assign bus.mgr_rsp_o[i].rvalid = pop & (head_idx == IdxW'(i));
        assign bus.mgr_rsp_o[i].rdata  = bus.out_rsp_i.rdata;
        assign bus.mgr_rsp_o[i].err    = bus.out_rsp_i.err;
        assign bus.mgr_rsp_o[i].rid    = bus.out_rsp_i.rid;
    end

    assign bus.outstanding_o = fifo_cnt;
    assign bus.unexp_rsp_o   = unexp_q;

    user_obi_id_fifo #(
        .Width (IdxW),
        .Depth (NumMaxTrans)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (arb_idx),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            unexp_q    <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            lock_q     <= out_req & ~bus.out_rsp_i.gnt;
            lock_idx_q <= arb_idx;
            if (RoundRobin && hs)
                rr_ptr_q <= (arb_idx == IdxW'(NumMgr - 1)) ? '0 : arb_idx + 1'b1;
            if (bus.out_rsp_i.rvalid && fifo_empty)
                unexp_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_user_obi_mgr_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter driven with
// directed cycles; a negedge monitor checks every grant/rvalid and status.
module tb_user_obi_mgr_arb;
    import user_obi_mgr_arb_pkg::*;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam int K_GNT = 0, K_RV = 1, K_REQ = 2, K_OUT = 3, K_UNEXP = 4;

    typedef struct {
        int          dut;
        int          kind;
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    user_obi_mgr_arb_if #(.NumMgr(2), .NumMaxTrans(4)) bus_a ();
    user_obi_mgr_arb_if #(.NumMgr(2), .NumMaxTrans(4)) bus_b ();

    user_obi_mgr_arb #(.NumMgr(2), .NumMaxTrans(4), .RoundRobin(1'b1)) u_dut (
        .clk_i (clk), .rst_i (rst), .bus (bus_a.slave));
    user_obi_mgr_arb #(.NumMgr(2), .NumMaxTrans(4), .RoundRobin(1'b0)) u_dut_fp (
        .clk_i (clk), .rst_i (rst), .bus (bus_b.slave));

    exp_t qa[$], qb[$], sq[$];
    int   n_vec = 0, n_err = 0;
    bit   done = 1'b0, fin_chk = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    task automatic match(input int dut, input int kind, input int idx, input logic [31:0] d);
        exp_t e;
        n_vec++;
        if ((dut == 0 && qa.size() == 0) || (dut == 1 && qb.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_evt dut%0d kind=%0d got idx=%0d data=%h, required none",
                     dut, kind, idx, d);
            return;
        end
        e = (dut == 0) ? qa.pop_front() : qb.pop_front();
        if (e.kind != kind || e.idx != idx || e.data !== d) begin
            n_err++;
            $display("FAIL evt dut%0d got kind=%0d idx=%0d data=%h, required kind=%0d idx=%0d data=%h",
                     dut, kind, idx, d, e.kind, e.idx, e.data);
        end
    endtask

    task automatic mon_dut(input int dut, input mgr_obi_rsp_t r0, input mgr_obi_rsp_t r1,
                           input logic [31:0] addr);
        if (r0.gnt === 1'b1)    match(dut, K_GNT, 0, addr);
        if (r1.gnt === 1'b1)    match(dut, K_GNT, 1, addr);
        if (r0.rvalid === 1'b1) match(dut, K_RV, 0, r0.rdata);
        if (r1.rvalid === 1'b1) match(dut, K_RV, 1, r1.rdata);
    endtask

    task automatic check_status(input exp_t e);
        logic        rq, ue;
        logic [31:0] ad, oc;
        if (e.dut == 0) begin
            rq = bus_a.out_req_o.req; ad = bus_a.out_req_o.addr;
            oc = 32'(bus_a.outstanding_o); ue = bus_a.unexp_rsp_o;
        end else begin
            rq = bus_b.out_req_o.req; ad = bus_b.out_req_o.addr;
            oc = 32'(bus_b.outstanding_o); ue = bus_b.unexp_rsp_o;
        end
        n_vec++;
        case (e.kind)
            K_REQ: if (rq !== e.idx[0] || (e.idx == 1 && ad !== e.data)) begin
                n_err++;
                $display("FAIL out_req dut%0d got req=%b addr=%h, required req=%0d addr=%h",
                         e.dut, rq, ad, e.idx, e.data);
            end
            K_OUT: if (oc !== e.data) begin
                n_err++;
                $display("FAIL outstanding dut%0d got %0d, required %0d", e.dut, oc, e.data);
            end
            default: if (ue !== e.data[0]) begin
                n_err++;
                $display("FAIL unexp_rsp dut%0d got %b, required %0d", e.dut, ue, e.data);
            end
        endcase
    endtask

    always @(negedge clk) begin
        mon_dut(0, bus_a.mgr_rsp_o[0], bus_a.mgr_rsp_o[1], bus_a.out_req_o.addr);
        mon_dut(1, bus_b.mgr_rsp_o[0], bus_b.mgr_rsp_o[1], bus_b.out_req_o.addr);
        while (sq.size() > 0) check_status(sq.pop_front());
        if (done && !fin_chk) begin
            fin_chk = 1'b1;
            n_vec++;
            if (qa.size() + qb.size() != 0) begin
                n_err++;
                $display("FAIL missing_evt got %0d unseen expected events, required 0",
                         qa.size() + qb.size());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int dut, input int kind, input int idx, input logic [31:0] d);
        exp_t e;
        e.dut = dut; e.kind = kind; e.idx = idx; e.data = d;
        if (kind >= K_REQ)  sq.push_back(e);
        else if (dut == 0)  qa.push_back(e);
        else                qb.push_back(e);
    endtask

    task automatic set_a(input bit r0, input bit r1, input bit g, input bit v, input logic [31:0] rd);
        bus_a.mgr_req_i[0].req = r0;
        bus_a.mgr_req_i[1].req = r1;
        bus_a.out_rsp_i.gnt    = g;
        bus_a.out_rsp_i.rvalid = v;
        bus_a.out_rsp_i.rdata  = rd;
    endtask

    task automatic set_b(input bit r0, input bit r1, input bit g, input bit v, input logic [31:0] rd);
        bus_b.mgr_req_i[0].req = r0;
        bus_b.mgr_req_i[1].req = r1;
        bus_b.out_rsp_i.gnt    = g;
        bus_b.out_rsp_i.rvalid = v;
        bus_b.out_rsp_i.rdata  = rd;
    endtask

    initial begin
        bus_a.mgr_req_i = '0; bus_a.out_rsp_i = '0;
        bus_b.mgr_req_i = '0; bus_b.out_rsp_i = '0;
        bus_a.mgr_req_i[0].addr = A0; bus_a.mgr_req_i[1].addr = A1;
        bus_b.mgr_req_i[0].addr = A0; bus_b.mgr_req_i[1].addr = A1;
        bus_a.mgr_req_i[1].we = 1'b1; bus_a.mgr_req_i[1].be = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // first cycle after reset: requests and gnt are held off
        set_a(1, 0, 1, 0, '0);
        ex(0, K_REQ, 0, '0); ex(0, K_OUT, 0, 0); ex(0, K_UNEXP, 0, 0);
        cyc();

        // round-robin alternation, rvalid one cycle after each grant
        for (int c = 0; c < 7; c++) begin
            set_a(c < 6, c < 6, c < 6, c > 0, 32'hD000 + 32'(c));
            if (c < 6) ex(0, K_GNT, c % 2, (c % 2) ? A1 : A0);
            if (c > 0) ex(0, K_RV, (c - 1) % 2, 32'hD000 + 32'(c));
            cyc();
        end
        set_a(0, 0, 0, 0, '0); ex(0, K_OUT, 0, 0); cyc();

        // stalled mgr1 stays selected when mgr0 joins
        repeat (3) begin
            set_a(0, 1, 0, 0, '0); ex(0, K_REQ, 1, A1); cyc();
        end
        set_a(1, 1, 0, 0, '0); ex(0, K_REQ, 1, A1); cyc();
        set_a(1, 1, 1, 0, '0); ex(0, K_GNT, 1, A1); cyc();
        set_a(1, 0, 1, 0, '0); ex(0, K_GNT, 0, A0); cyc();
        set_a(0, 0, 0, 1, 32'hE1); ex(0, K_RV, 1, 32'hE1); cyc();
        set_a(0, 0, 0, 1, 32'hE2); ex(0, K_RV, 0, 32'hE2); cyc();
        set_a(0, 0, 0, 0, '0); ex(0, K_OUT, 0, 0); cyc();

        // fill to NumMaxTrans, then blocked until a pop has taken effect
        repeat (4) begin
            set_a(1, 0, 1, 0, '0); ex(0, K_GNT, 0, A0); cyc();
        end
        set_a(1, 0, 1, 0, '0); ex(0, K_REQ, 0, '0); ex(0, K_OUT, 0, 4); cyc();
        set_a(1, 0, 1, 1, 32'hF0);
        ex(0, K_REQ, 0, '0); ex(0, K_OUT, 0, 4); ex(0, K_RV, 0, 32'hF0); cyc();
        set_a(1, 0, 1, 0, '0);
        ex(0, K_OUT, 0, 3); ex(0, K_REQ, 1, A0); ex(0, K_GNT, 0, A0); cyc();
        for (int c = 1; c <= 4; c++) begin
            set_a(0, 0, 0, 1, 32'hF0 + 32'(c)); ex(0, K_RV, 0, 32'hF0 + 32'(c)); cyc();
        end
        set_a(0, 0, 0, 0, '0); ex(0, K_OUT, 0, 0); ex(0, K_UNEXP, 0, 0); cyc();

        // reset with two outstanding, then a stray rvalid
        repeat (2) begin
            set_a(0, 1, 1, 0, '0); ex(0, K_GNT, 1, A1); cyc();
        end
        set_a(0, 0, 0, 0, '0); ex(0, K_OUT, 0, 2); cyc();
        rst = 1'b1;
        set_a(1, 0, 1, 1, 32'hAA); ex(0, K_REQ, 0, '0); cyc();
        rst = 1'b0;
        set_a(1, 0, 1, 0, '0);
        ex(0, K_REQ, 0, '0); ex(0, K_OUT, 0, 0); ex(0, K_UNEXP, 0, 0); cyc();
        set_a(0, 0, 0, 1, 32'hBB); ex(0, K_UNEXP, 0, 0); cyc();
        set_a(0, 0, 0, 0, '0); ex(0, K_UNEXP, 0, 1); cyc();
        set_a(1, 0, 1, 0, '0); ex(0, K_GNT, 0, A0); ex(0, K_UNEXP, 0, 1); cyc();
        set_a(0, 0, 0, 1, 32'hC0); ex(0, K_RV, 0, 32'hC0); ex(0, K_UNEXP, 0, 1); cyc();
        set_a(0, 0, 0, 0, '0); rst = 1'b1; cyc();
        rst = 1'b0; ex(0, K_UNEXP, 0, 0); ex(0, K_OUT, 0, 0); cyc();

        // fixed priority: mgr0 wins every cycle, mgr1 starves
        for (int c = 0; c < 5; c++) begin
            set_b(c < 4, c < 4, c < 4, c > 0, 32'hB000 + 32'(c));
            if (c < 4) ex(1, K_GNT, 0, A0);
            if (c > 0) ex(1, K_RV, 0, 32'hB000 + 32'(c));
            cyc();
        end
        set_b(0, 0, 0, 0, '0); ex(1, K_OUT, 0, 0); ex(1, K_UNEXP, 0, 0); cyc();

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
